control_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 61 ++++++
 rtl/microcode_rom.sv | 90 +++++++++
 rtl/control_unit.sv | 46 ++++
 tb/tb_control_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, microstep and control-word types for the SAP-1.5 control unit
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_LDB = 4'h2,
    OP_ADD = 4'h3,
    OP_SUB = 4'h4,
    OP_STA = 4'h5,
    OP_LDI = 4'h6,
    OP_JMP = 4'h7,
    OP_JC  = 4'h8,
    OP_JZ  = 4'h9,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef logic [2:0] step_t;

  localparam step_t T0 = 3'd0;
  localparam step_t T1 = 3'd1;
  localparam step_t T2 = 3'd2;
  localparam step_t T3 = 3'd3;
  localparam step_t T4 = 3'd4;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } cu_state_t;

  // Declared MSB first so that pc_enable lands on bit 0.
  typedef struct packed {
    logic spare;
    logic load_o;
    logic load_flags;
    logic oe_alu;
    logic alu_sub;
    logic load_b;
    logic oe_a;
    logic load_a;
    logic oe_ir;
    logic load_ir;
    logic load_ram;
    logic oe_ram;
    logic load_mar;
    logic oe_pc;
    logic load_pc;
    logic pc_enable;
  } control_word_t;

  // Final T-state of each instruction; the step counter wraps to T0 after it.
  function automatic step_t last_step(input logic [3:0] op);
    case (op)
      OP_LDA, OP_LDB, OP_STA: last_step = T3;
      OP_ADD, OP_SUB:         last_step = T4;
      default:                last_step = T2;
    endcase
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// rtl/microcode_rom.sv - combinational (step, opcode, flags) to control-word decode; JC/JZ gated by CU_COND_JUMP_EN
module microcode_rom
  import cpu_pkg::*;
(
  input  step_t         step,
  input  logic [3:0]    opcode,
  input  logic          flag_zero,
  input  logic          flag_carry,
  output control_word_t word
);

`ifndef CU_COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = flag_zero ^ flag_carry;
`endif

  always_comb begin
    word = '0;
    case (step)
      T0: begin
        word.oe_pc    = 1'b1;
        word.load_mar = 1'b1;
      end
      T1: begin
        word.oe_ram    = 1'b1;
        word.load_ir   = 1'b1;
        word.pc_enable = 1'b1;
      end
      T2: begin
        case (opcode)
          OP_LDA, OP_LDB, OP_ADD, OP_SUB, OP_STA: begin
            word.oe_ir    = 1'b1;
            word.load_mar = 1'b1;
          end
          OP_LDI: begin
            word.oe_ir  = 1'b1;
            word.load_a = 1'b1;
          end
          OP_JMP: begin
            word.oe_ir   = 1'b1;
            word.load_pc = 1'b1;
          end
`ifdef CU_COND_JUMP_EN
          // An untaken jump leaves the bus undriven as well.
          OP_JC: begin
            word.oe_ir   = flag_carry;
            word.load_pc = flag_carry;
          end
          OP_JZ: begin
            word.oe_ir   = flag_zero;
            word.load_pc = flag_zero;
          end
`endif
          OP_OUT: begin
            word.oe_a   = 1'b1;
            word.load_o = 1'b1;
          end
          default: ;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: begin
            word.oe_ram = 1'b1;
            word.load_a = 1'b1;
          end
          OP_LDB, OP_ADD, OP_SUB: begin
            word.oe_ram = 1'b1;
            word.load_b = 1'b1;
          end
          OP_STA: begin
            word.oe_a     = 1'b1;
            word.load_ram = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          word.oe_alu     = 1'b1;
          word.load_a     = 1'b1;
          word.load_flags = 1'b1;
          word.alu_sub    = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - SAP-1.5 T-state sequencer and halt FSM; conditional jumps enabled by CU_COND_JUMP_EN
module control_unit
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    opcode,
  input  logic          flag_zero,
  input  logic          flag_carry,
  output control_word_t ctrl,
  output step_t         step,
  output logic          halt
);

  cu_state_t     state;
  control_word_t rom_word;

  microcode_rom u_rom (
    .step       (step),
    .opcode     (opcode),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .word       (rom_word)
  );

  // Opcode is stale during fetch; last_step never ends before T2, so T0/T1 always advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_RUN;
      step  <= T0;
      halt  <= 1'b0;
    end else if (state == ST_RUN) begin
      if (step == T2 && opcode == OP_HLT) begin
        state <= ST_HALTED;
        halt  <= 1'b1;
      end else if (step == last_step(opcode)) begin
        step <= T0;
      end else begin
        step <= step + 3'd1;
      end
    end
  end

  assign ctrl = (reset || state == ST_HALTED) ? '0 : rom_word;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - SAP-1.5 datapath around control_unit checked against an ISA-level reference model
module tb_control_unit;
  import cpu_pkg::*;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  control_word_t ctrl;
  step_t         step;
  logic          halt;

  logic [3:0] pc, mar;
  logic [7:0] ir, a, b, outr, bus;
  logic       zf, cf;
  logic [7:0] mem [16];
  logic [7:0] img [16];
  logic       load_img = 1'b0;
  int         ram_writes;
  logic [8:0] alu;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (ir[7:4]),
    .flag_zero  (zf),
    .flag_carry (cf),
    .ctrl       (ctrl),
    .step       (step),
    .halt       (halt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bench-side datapath driven by the control word.
  always_comb begin
    bus = 8'h00;
    if (ctrl.oe_pc)  bus = {4'h0, pc};
    if (ctrl.oe_ram) bus = mem[mar];
    if (ctrl.oe_ir)  bus = {4'h0, ir[3:0]};
    if (ctrl.oe_a)   bus = a;
    if (ctrl.oe_alu) bus = alu[7:0];
  end

  assign alu = {1'b0, a} + {1'b0, (ctrl.alu_sub ? ~b : b)} + {8'h00, ctrl.alu_sub};

  always @(posedge clk) begin
    if (load_img) begin
      mem <= img;
      ram_writes <= 0;
    end
    if (reset) begin
      pc <= 4'h0; mar <= 4'h0; ir <= 8'h00; a <= 8'h00; b <= 8'h00;
      outr <= 8'h00; zf <= 1'b0; cf <= 1'b0;
    end else begin
      if (ctrl.load_ram) begin
        mem[mar] <= bus;
        ram_writes <= ram_writes + 1;
      end
      if (ctrl.load_mar)   mar <= bus[3:0];
      if (ctrl.load_ir)    ir <= bus;
      if (ctrl.load_a)     a <= bus;
      if (ctrl.load_b)     b <= bus;
      if (ctrl.load_o)     outr <= bus;
      if (ctrl.pc_enable)  pc <= pc + 4'h1;
      if (ctrl.load_pc)    pc <= bus[3:0];
      if (ctrl.load_flags) begin
        zf <= (alu[7:0] == 8'h00);
        cf <= alu[8];
      end
    end
  end

  // Per-cycle invariants.
  always @(negedge clk) begin
    #1;
    check("oe_single", 32'(int'(ctrl.oe_pc) + int'(ctrl.oe_ram) + int'(ctrl.oe_ir)
                        + int'(ctrl.oe_a) + int'(ctrl.oe_alu)) <= 32'd1, 1);
    check("spare", ctrl.spare, 0);
    if (ctrl.load_flags) check("flags_t4", step, 4);
    if (reset) check("reset_ctrl", ctrl, 0);
    if (halt)  check("halt_ctrl", ctrl, 0);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    load_img = 1'b1;
    @(negedge clk);
    @(negedge clk);
    load_img = 1'b0;
    reset = 1'b0;
  endtask

  // ISA-level reference: one instruction at a time, compared after each completes.
  task automatic run_model(input int max_instr);
    logic [7:0] rm [16];
    logic [3:0] rpc, op, arg;
    logic [7:0] ra, rb, rout, ins;
    logic       rz, rc;
    int         s, exp_cyc, cyc;
    rm = img;
    rpc = 4'h0; ra = 8'h00; rb = 8'h00; rout = 8'h00; rz = 1'b0; rc = 1'b0;
    for (int n = 0; n < max_instr; n++) begin
      check("t0_step", step, 0);
      ins = rm[rpc]; op = ins[7:4]; arg = ins[3:0];
      rpc = rpc + 4'h1;
      exp_cyc = 3;
      case (op)
        4'h1: begin ra = rm[arg]; exp_cyc = 4; end
        4'h2: begin rb = rm[arg]; exp_cyc = 4; end
        4'h3: begin
          rb = rm[arg];
          s = int'(ra) + int'(rb);
          rc = (s > 255); ra = 8'(s % 256); rz = (ra == 8'h00); exp_cyc = 5;
        end
        4'h4: begin
          rb = rm[arg];
          rc = (ra >= rb); ra = ra - rb; rz = (ra == 8'h00); exp_cyc = 5;
        end
        4'h5: begin rm[arg] = ra; exp_cyc = 4; end
        4'h6: ra = {4'h0, arg};
        4'h7: rpc = arg;
`ifdef CU_COND_JUMP_EN
        4'h8: if (rc) rpc = arg;
        4'h9: if (rz) rpc = arg;
`endif
        4'hE: rout = ra;
        default: ;
      endcase
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (step != 3'd0 && !halt && cyc < 8);
      check("cycles", cyc, exp_cyc);
      check("halt", halt, (op == 4'hF));
      check("reg_a", a, ra);
      check("reg_b", b, rb);
      check("pc", pc, rpc);
      check("out", outr, rout);
      check("flag_z", zf, rz);
      check("flag_c", cf, rc);
      if (op == 4'h5) check("sta_mem", mem[arg], rm[arg]);
      if (op == 4'hF) begin
        repeat (3) begin
          @(negedge clk);
          check("halted", halt, 1);
          check("halted_step", step, 2);
        end
        return;
      end
    end
  endtask

  task automatic run_prog(input int max_instr);
    do_reset();
    run_model(max_instr);
  endtask

  initial begin
    img = '{default: 8'h00};
    repeat (2) @(negedge clk);
    check("rst_step", step, 0);
    check("rst_halt", halt, 0);
    check("rst_ctrl", ctrl, 0);

    img = '{default: 8'h00}; img[0] = 8'h68; img[1] = 8'hF0;
    run_prog(10);

    img = '{default: 8'h00}; img[0] = 8'h1E; img[1] = 8'h3F; img[2] = 8'hF0;
    img[14] = 8'h05; img[15] = 8'hFE;
    run_prog(10);

    img = '{default: 8'h00}; img[0] = 8'h60; img[1] = 8'h4F; img[2] = 8'h95;
    img[3] = 8'hF0; img[5] = 8'hF0;
    run_prog(10);
    img[0] = 8'h61;
    run_prog(10);

    img = '{default: 8'h00}; img[0] = 8'h1F; img[1] = 8'hB0; img[2] = 8'hE0;
    img[3] = 8'hF0; img[15] = 8'h2A;
    run_prog(10);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
      img[15] = 8'hF0;
      run_prog(30);
    end

    // Reset during T3 of STA must suppress the write and restart from address 0.
    img = '{default: 8'h00}; img[0] = 8'h67; img[1] = 8'h5F; img[2] = 8'hF0;
    do_reset();
    for (int i = 0; i < 20 && step != 3'd3; i++) @(negedge clk);
    check("sta_t3_reached", step, 3);
    reset = 1'b1;
    #1;
    check("mid_rst_ctrl", ctrl, 0);
    @(negedge clk);
    check("mid_rst_step", step, 0);
    reset = 1'b0;
    #1;
    check("no_ram_write", ram_writes, 0);
    check("mem_intact", mem[15], 8'h00);
    run_model(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
